// File: rtl/hwpe_tcdm_mux_pkg.sv
// Shared types and default sizing for the HWPE TCDM request multiplexer.
// The port-index type is sized for the largest supported fan-in.
package hwpe_tcdm_mux_package;

    localparam int unsigned DEFAULT_NB_IN           = 3;
    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;
    localparam int unsigned PORT_IDX_W              = 8;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage

// File: rtl/hwpe_tcdm_mux_id_fifo.sv
// In-order FIFO of granted port indices; the head names the port owed the next response.
module hwpe_tcdm_mux_id_fifo
    import hwpe_tcdm_mux_package::*;
#(
    parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  port_idx_t        push_id,
    input  logic             pop,
    output port_idx_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    port_idx_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // simultaneous push and pop leaves the occupancy unchanged
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hwpe_tcdm_mux.sv
// Round-robin merge of NB_IN HWPE TCDM masters onto one memory port,
// with in-order response routing through an ID FIFO.
module hwpe_tcdm_mux
    import hwpe_tcdm_mux_package::*;
#(
    parameter int unsigned NB_IN           = DEFAULT_NB_IN,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NB_IN-1:0]                    in_req,
    output logic [NB_IN-1:0]                    in_gnt,
    input  logic [NB_IN-1:0][ADDR_WIDTH-1:0]    in_add,
    input  logic [NB_IN-1:0]                    in_wen,
    input  logic [NB_IN-1:0][BE_WIDTH-1:0]      in_be,
    input  logic [NB_IN-1:0][DATA_WIDTH-1:0]    in_data,
    output logic [NB_IN-1:0][DATA_WIDTH-1:0]    in_r_data,
    output logic [NB_IN-1:0]                    in_r_valid,
    output logic                                out_req,
    output logic [ADDR_WIDTH-1:0]               out_add,
    output logic                                out_wen,
    output logic [BE_WIDTH-1:0]                 out_be,
    output logic [DATA_WIDTH-1:0]               out_data,
    input  logic                                out_gnt,
    input  logic [DATA_WIDTH-1:0]               out_r_data,
    input  logic                                out_r_valid,
    output logic [CNT_W-1:0]                    outstanding_o,
    output logic                                err_o
);

    localparam int unsigned IDX_W = (NB_IN > 1) ? $clog2(NB_IN) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             handshake;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    port_idx_t        fifo_head;

    // First requester at or after rr_ptr; the wrap is a subtraction since rr_ptr + i < 2*NB_IN.
    always_comb begin
        int unsigned cand;
        logic        found;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NB_IN; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NB_IN) begin
                cand = cand - NB_IN;
            end
            if (!found && in_req[cand]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        any_req   = |in_req;
        out_req   = any_req && !fifo_full && !rst_i;
        handshake = out_req && out_gnt;
        out_add   = in_add[winner];
        out_wen   = in_wen[winner];
        out_be    = in_be[winner];
        out_data  = in_data[winner];
        fifo_pop  = out_r_valid && !fifo_empty && !rst_i;
        for (int unsigned i = 0; i < NB_IN; i++) begin
            in_gnt[i]     = handshake && (winner == IDX_W'(i));
            in_r_valid[i] = fifo_pop && (fifo_head == port_idx_t'(i));
            in_r_data[i]  = out_r_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= (winner == IDX_W'(NB_IN - 1)) ? '0 : winner + 1'b1;
            end
            if (out_r_valid && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    hwpe_tcdm_mux_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (handshake),
        .push_id (port_idx_t'(winner)),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .count   (outstanding_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_hwpe_tcdm_mux.sv
// Directed self-checking bench for hwpe_tcdm_mux with the default 3-port, 4-deep configuration.
module tb_hwpe_tcdm_mux;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [2:0]        in_req;
    logic [2:0]        in_gnt;
    logic [2:0][31:0]  in_add;
    logic [2:0]        in_wen;
    logic [2:0][3:0]   in_be;
    logic [2:0][31:0]  in_data;
    logic [2:0][31:0]  in_r_data;
    logic [2:0]        in_r_valid;
    logic              out_req;
    logic [31:0]       out_add;
    logic              out_wen;
    logic [3:0]        out_be;
    logic [31:0]       out_data;
    logic              out_gnt;
    logic [31:0]       out_r_data;
    logic              out_r_valid;
    logic [2:0]        outstanding_o;
    logic              err_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    hwpe_tcdm_mux #(
        .NB_IN           (3),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_req        (in_req),
        .in_gnt        (in_gnt),
        .in_add        (in_add),
        .in_wen        (in_wen),
        .in_be         (in_be),
        .in_data       (in_data),
        .in_r_data     (in_r_data),
        .in_r_valid    (in_r_valid),
        .out_req       (out_req),
        .out_add       (out_add),
        .out_wen       (out_wen),
        .out_be        (out_be),
        .out_data      (out_data),
        .out_gnt       (out_gnt),
        .out_r_data    (out_r_data),
        .out_r_valid   (out_r_valid),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i       = 1'b1;
        in_req      = '0;
        in_wen      = '1;
        in_be       = '1;
        in_add      = '0;
        in_data     = '0;
        out_gnt     = 1'b0;
        out_r_data  = '0;
        out_r_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_add[i]  = 32'h1000 + 32'(i);
            in_data[i] = 32'h5000 + 32'(i);
        end
        step();
        step();

        // outputs forced quiet while reset is held, even with live inputs
        in_req = 3'b111; out_gnt = 1'b1; out_r_valid = 1'b1;
        sample();
        chk("rst_out_req", 64'(out_req), 64'd0);
        chk("rst_in_gnt", 64'(in_gnt), 64'd0);
        chk("rst_in_r_valid", 64'(in_r_valid), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        step();
        rst_i = 1'b0; in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b0;
        sample();
        chk("post_rst_err", 64'(err_o), 64'd0);
        step();

        // single read from port 0
        in_req = 3'b001; in_add[0] = 32'h100; out_gnt = 1'b1;
        sample();
        chk("rd_in_gnt", 64'(in_gnt), 64'b001);
        chk("rd_out_add", 64'(out_add), 64'h100);
        chk("rd_out_wen", 64'(out_wen), 64'd1);
        step();
        in_req = '0; out_r_valid = 1'b1; out_r_data = 32'hDEADBEEF;
        sample();
        chk("rd_in_r_valid", 64'(in_r_valid), 64'b001);
        chk("rd_in_r_data0", 64'(in_r_data[0]), 64'hDEADBEEF);
        chk("rd_in_r_data2", 64'(in_r_data[2]), 64'hDEADBEEF);
        chk("rd_outstanding", 64'(outstanding_o), 64'd1);
        step();
        out_r_valid = 1'b0;
        sample();
        chk("rd_drained", 64'(outstanding_o), 64'd0);
        in_add[0] = 32'h1000;

        // back to rr_ptr = 0, then all three ports stream
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        in_req = 3'b111; out_gnt = 1'b1;
        for (int k = 0; k < 6; k++) begin
            out_r_valid = (k > 0);
            out_r_data  = 32'hA000 + 32'(k);
            sample();
            chk($sformatf("rr_gnt_%0d", k), 64'(in_gnt), 64'(3'b001 << (k % 3)));
            chk($sformatf("rr_add_%0d", k), 64'(out_add), 64'(32'h1000 + 32'(k % 3)));
            if (k > 0) begin
                chk($sformatf("rr_rvalid_%0d", k), 64'(in_r_valid), 64'(3'b001 << ((k - 1) % 3)));
                chk($sformatf("rr_cnt_%0d", k), 64'(outstanding_o), 64'd1);
            end
            step();
        end
        in_req = '0; out_r_valid = 1'b1;
        sample();
        chk("rr_rvalid_last", 64'(in_r_valid), 64'b100);
        step();
        out_r_valid = 1'b0; out_gnt = 1'b0;
        sample();
        chk("rr_drained", 64'(outstanding_o), 64'd0);

        // port 1 stalled by memory for five cycles
        in_req = 3'b010; in_add[1] = 32'h200;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk($sformatf("stall_gnt_%0d", k), 64'(in_gnt), 64'd0);
            chk($sformatf("stall_add_%0d", k), 64'(out_add), 64'h200);
            chk($sformatf("stall_req_%0d", k), 64'(out_req), 64'd1);
            step();
        end
        out_gnt = 1'b1;
        sample();
        chk("stall_gnt_6", 64'(in_gnt), 64'b010);
        step();
        in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b1;
        sample();
        chk("stall_rvalid", 64'(in_r_valid), 64'b010);
        step();
        out_r_valid = 1'b0;
        in_add[1] = 32'h1001;

        // fill to MAX_OUTSTANDING with responses withheld; rr_ptr is 2 here
        in_req = 3'b111; out_gnt = 1'b1;
        chk_fill: for (int k = 0; k < 4; k++) begin
            sample();
            chk($sformatf("fill_gnt_%0d", k), 64'(in_gnt), 64'(3'b001 << ((k + 2) % 3)));
            step();
        end
        sample();
        chk("full_out_req", 64'(out_req), 64'd0);
        chk("full_in_gnt", 64'(in_gnt), 64'd0);
        chk("full_cnt", 64'(outstanding_o), 64'd4);
        step();
        out_r_valid = 1'b1;
        sample();
        chk("full_pop_rvalid", 64'(in_r_valid), 64'b100);
        chk("full_no_credit", 64'(out_req), 64'd0);
        step();
        out_r_valid = 1'b0;
        sample();
        chk("refill_req", 64'(out_req), 64'd1);
        chk("refill_cnt", 64'(outstanding_o), 64'd3);
        chk("refill_gnt", 64'(in_gnt), 64'b001);
        step();
        in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk($sformatf("drain_rvalid_%0d", k), 64'(in_r_valid), 64'(3'b001 << (k % 3)));
            step();
        end
        out_r_valid = 1'b0;
        sample();
        chk("drain_cnt", 64'(outstanding_o), 64'd0);

        // two outstanding with rr_ptr = 2, then reset mid-flight
        in_req = 3'b001; out_gnt = 1'b1;
        step();
        in_req = 3'b010;
        sample();
        chk("pre_rst_gnt", 64'(in_gnt), 64'b010);
        step();
        in_req = '0; out_gnt = 1'b0;
        sample();
        chk("pre_rst_cnt", 64'(outstanding_o), 64'd2);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        sample();
        chk("mid_rst_cnt", 64'(outstanding_o), 64'd0);

        // late response with nothing outstanding
        out_r_valid = 1'b1;
        sample();
        chk("late_no_rvalid", 64'(in_r_valid), 64'd0);
        step();
        out_r_valid = 1'b0;
        sample();
        chk("err_set", 64'(err_o), 64'd1);
        step();
        in_req = 3'b101; out_gnt = 1'b1;
        sample();
        chk("err_sticky", 64'(err_o), 64'd1);
        chk("post_rst_gnt", 64'(in_gnt), 64'b001);
        step();
        in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b1;
        sample();
        chk("post_rst_rvalid", 64'(in_r_valid), 64'b001);
        step();
        out_r_valid = 1'b0;
        sample();
        chk("err_still_set", 64'(err_o), 64'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        sample();
        chk("err_cleared", 64'(err_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/hwpe_tcdm_mux.md
HWPE_TCDM_MUX -- requirements
Module: hwpe_tcdm_mux

Interface
REQ-001 Parameter NB_IN, default 3: number of HWPE TCDM master ports merged onto one memory port.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.
REQ-004 Parameter MAX_OUTSTANDING, default 4: maximum granted transactions still awaiting a response.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock; all state updates on the rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 in_req  in  NB_IN  per-port request.
REQ-009 in_gnt  out  NB_IN  per-port grant.
REQ-010 in_add  in  NB_IN x ADDR_WIDTH  per-port address.
REQ-011 in_wen  in  NB_IN  per-port write-enable, active-low: 1 = read.
REQ-012 in_be  in  NB_IN x DATA_WIDTH/8  per-port byte enables.
REQ-013 in_data  in  NB_IN x DATA_WIDTH  per-port write data.
REQ-014 in_r_data  out  NB_IN x DATA_WIDTH  per-port response data.
REQ-015 in_r_valid  out  NB_IN  per-port response valid.
REQ-016 out_req, out_add, out_wen, out_be, out_data  out  1 / ADDR_WIDTH / 1 / DATA_WIDTH/8 / DATA_WIDTH  merged request to memory.
REQ-017 out_gnt  in  1  memory grant.
REQ-018 out_r_data  in  DATA_WIDTH  memory response data.
REQ-019 out_r_valid  in  1  memory response valid.
REQ-020 outstanding_o  out  clog2(MAX_OUTSTANDING+1)  count of in-flight transactions.
REQ-021 err_o  out  1  sticky flag: response received with nothing outstanding.

Function
REQ-022 out_req SHALL equal OR(in_req) AND NOT full; full means outstanding == MAX_OUTSTANDING, with no same-cycle pop credit.
REQ-023 Winner SHALL be the first requesting port at or after rr_ptr, modulo NB_IN; out_add/wen/be/data SHALL be the winner's fields, combinationally.
REQ-024 in_gnt[winner] SHALL equal out_req AND out_gnt; all other in_gnt bits SHALL be 0.
REQ-025 On handshake (out_req AND out_gnt), winner index SHALL be pushed to the ID FIFO and rr_ptr SHALL become (winner+1) mod NB_IN.
REQ-026 Without a handshake, rr_ptr SHALL hold.
REQ-027 Memory responds in order, at least one cycle after grant, for reads and writes alike.
REQ-028 On out_r_valid with FIFO non-empty: in_r_valid[head] = 1 in the same cycle; the head is popped.
REQ-029 in_r_data SHALL broadcast out_r_data to all ports.
REQ-030 Same-cycle push and pop SHALL leave outstanding_o unchanged and preserve order.
REQ-031 out_r_valid with FIFO empty SHALL drive no in_r_valid and SHALL set err_o, which holds until reset.
REQ-032 A requester deasserting without a grant is legal; the mux SHALL not latch request fields.

Reset
REQ-033 rst_i SHALL set rr_ptr = 0, empty the FIFO (outstanding_o = 0) and clear err_o.
REQ-034 While rst_i = 1: out_req = 0, in_gnt = 0, in_r_valid = 0.
REQ-035 Reset mid-operation SHALL discard outstanding IDs; late responses are then handled per REQ-031.

Structure
REQ-036 Shared package hwpe_tcdm_mux_package SHALL hold the port-index typedef and the default NB_IN/MAX_OUTSTANDING constants.
REQ-037 The ID FIFO SHALL be sub-module hwpe_tcdm_mux_id_fifo (push, pop, head, count, full, empty); arbitration lives in the top.

Verification
REQ-038 Port 0 reads 0x100 with out_gnt = 1; out_r_valid the next cycle with 0xDEADBEEF -> in_gnt[0] on the request cycle; in_r_valid[0] = 1 with in_r_data 0xDEADBEEF one cycle later.
REQ-039 All three ports request continuously, out_gnt = 1, one-cycle responses -> grant order 0,1,2,0,1,2; responses route in the same order.
REQ-040 Port 1 requests 0x200 with out_gnt = 0 for 5 cycles -> in_gnt = 0 and out_add = 0x200 stable; grant lands on cycle 6.
REQ-041 MAX_OUTSTANDING = 4, responses withheld -> four grants, then out_req = 0 and outstanding_o = 4; one out_r_valid -> out_req = 1 the next cycle.
REQ-042 out_r_valid with the FIFO empty -> err_o = 1 and stays set, no in_r_valid; rst_i clears it.
REQ-043 rst_i with 2 outstanding after rr_ptr = 2 -> outstanding_o = 0; the next simultaneous requests from ports 0 and 2 grant port 0 first.
